// File: rtl/ram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// ram_arb_ctrl
//
// Front end for the shared 256x8 scratch RAM. Two phases:
//   INIT  : clears every RAM location to zero, one write per clock, starting
//           at address 0 after reset release or after an init_start request.
//   SERVE : shares the single RAM port among NREQ requesters with a
//           round-robin arbiter and returns read data tagged with the owner.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   init_start            request a full re-clear (only honoured in SERVE)
//   init_busy             high while the clear is in progress
//   init_done             one-cycle pulse on the first SERVE cycle after a clear
//   req / req_we          per-requester request and write-enable
//   req_addr / req_wdata  packed per-requester address and write data,
//                         requester i at [i*AW +: AW] / [i*DW +: DW]
//   gnt                   one-hot, one-cycle grant pulse
//   mem_en / mem_we       RAM command strobes
//   mem_addr / mem_wdata  RAM address and write data
//   mem_rdata             RAM read data, valid the cycle after a read command
//   rd_valid / rd_id      read return strobe and owning requester
//   rd_data               mem_rdata passed straight through
//
// Handshake: a requester raises req[i] with its command fields stable and
// keeps them until it sees gnt[i] high for one cycle; the command is on the
// RAM port in that same cycle. The requester then drops req[i] (or presents a
// new command). A requester that is being granted is masked from the next
// arbitration, so a lone requester is served at most every other cycle.
//
// The FSM state is held in the signal 'state' (type state_t).
// ---------------------------------------------------------------------------
module ram_arb_ctrl #(
   parameter  int NREQ = 4,
   parameter  int AW   = 8,
   parameter  int DW   = 8,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init_start,
   output logic               init_busy,
   output logic               init_done,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic               mem_en,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata,
   output logic               rd_valid,
   output logic [DW-1:0]      rd_data,
   output logic [IDW-1:0]     rd_id
);

   typedef enum logic {ST_INIT = 1'b0, ST_SERVE = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_addr, clr_addr_nxt;
   logic [IDW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [IDW-1:0]    cmd_id, cmd_id_nxt;     // owner of the command on the RAM port
   logic [NREQ-1:0]   gnt_nxt;
   logic              mem_en_nxt, mem_we_nxt;
   logic [AW-1:0]     mem_addr_nxt;
   logic [DW-1:0]     mem_wdata_nxt;
   logic              rd_valid_nxt;
   logic [IDW-1:0]    rd_id_nxt;
   logic              init_busy_nxt, init_done_nxt;

   logic [NREQ-1:0]   elig;
   logic [IDW:0]      pick;                   // {found, index}
   logic [IDW-1:0]    pick_idx;

   // First eligible requester at or above ptr, wrapping at NREQ.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] e,
                                            input logic [IDW-1:0]  ptr);
      logic [IDW:0] res;
      int           c;
      res = '0;
      for (int off = 0; off < NREQ; off++) begin
         c = (int'(ptr) + off) % NREQ;
         if (!res[IDW] && e[c]) begin
            res = {1'b1, c[IDW-1:0]};
         end
      end
      return res;
   endfunction

   // A requester granted this cycle still has req high; mask it so the
   // same command is not granted twice.
   assign elig     = req & ~gnt;
   assign pick     = rr_pick(elig, rr_ptr);
   assign pick_idx = pick[IDW-1:0];

   assign rd_data  = mem_rdata;

   always_comb begin
      state_nxt     = state;
      clr_addr_nxt  = clr_addr;
      rr_ptr_nxt    = rr_ptr;
      cmd_id_nxt    = cmd_id;
      gnt_nxt       = '0;
      mem_en_nxt    = 1'b0;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      init_busy_nxt = init_busy;
      init_done_nxt = 1'b0;
      // Read returns follow the command on the port by one cycle, whatever
      // state the sequencer has moved to in the meantime.
      rd_valid_nxt  = mem_en & ~mem_we;
      rd_id_nxt     = (mem_en & ~mem_we) ? cmd_id : rd_id;

      case (state)
         ST_INIT: begin
            mem_en_nxt    = 1'b1;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = clr_addr;
            mem_wdata_nxt = '0;
            init_busy_nxt = 1'b1;
            clr_addr_nxt  = clr_addr + 1'b1;
            if (clr_addr == '1) begin
               state_nxt = ST_SERVE;
            end
         end

         ST_SERVE: begin
            // init_busy is still high on the first SERVE edge after a clear;
            // that edge is where the done pulse is launched.
            init_busy_nxt = 1'b0;
            init_done_nxt = init_busy;
            if (init_start) begin
               state_nxt     = ST_INIT;
               init_busy_nxt = 1'b1;
               clr_addr_nxt  = '0;
            end else if (pick[IDW]) begin
               gnt_nxt[pick_idx] = 1'b1;
               mem_en_nxt        = 1'b1;
               mem_we_nxt        = req_we[pick_idx];
               mem_addr_nxt      = req_addr[pick_idx*AW +: AW];
               mem_wdata_nxt     = req_wdata[pick_idx*DW +: DW];
               cmd_id_nxt        = pick_idx;
               rr_ptr_nxt        = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
            end
         end

         default: begin
            state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         clr_addr  <= '0;
         rr_ptr    <= '0;
         cmd_id    <= '0;
         gnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_valid  <= 1'b0;
         rd_id     <= '0;
         init_busy <= 1'b1;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         clr_addr  <= clr_addr_nxt;
         rr_ptr    <= rr_ptr_nxt;
         cmd_id    <= cmd_id_nxt;
         gnt       <= gnt_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         rd_valid  <= rd_valid_nxt;
         rd_id     <= rd_id_nxt;
         init_busy <= init_busy_nxt;
         init_done <= init_done_nxt;
      end
   end

endmodule
